// File: rtl/simple_spi_master.sv
// simple_spi_master: single-word SPI master with a mode-0 core and CPOL inversion.
// All pins are registered; MISO is sampled on the last cycle of each SCK high phase.
module simple_spi_master #(
    parameter int unsigned WIDTH       = 32,
    parameter logic        CPOL        = 1'b0,
    parameter int unsigned HALF_PERIOD = 4
) (
    input  logic             system_clk,
    input  logic             system_nrst,
    input  logic             start,
    input  logic [WIDTH-1:0] value_mosi,
    output logic [WIDTH-1:0] value_miso,
    output logic             busy,
    output logic             done,
    output logic             pin_ncs,
    output logic             pin_clk,
    output logic             pin_mosi,
    input  logic             pin_miso
);
    localparam int TW = $clog2(HALF_PERIOD + 1);
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [TW-1:0] T_LOAD = TW'(HALF_PERIOD - 1);
    localparam logic [BW-1:0] N_BITS = BW'(WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCK_HIGH,
        SCK_LOW,
        GAP
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [TW-1:0]    tmr;
    logic [BW-1:0]    bits;
    logic [WIDTH-1:0] shreg;
    logic             last;
    logic             ncs_d;
    logic             clk_d;
    logic             mosi_d;
    logic             busy_d;
    logic             done_d;

    assign last = (tmr == '0);

    always_ff @(posedge system_clk or negedge system_nrst) begin
        if (!system_nrst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     if (start) state_nx = SETUP;
            SETUP:    if (last) state_nx = SCK_HIGH;
            SCK_HIGH: if (last) state_nx = SCK_LOW;
            SCK_LOW:  if (last) state_nx = (bits < N_BITS) ? SCK_HIGH : GAP;
            GAP:      if (last) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Pin values are derived from the next state so they switch with it.
    always_comb begin
        ncs_d  = !(state_nx inside {SETUP, SCK_HIGH, SCK_LOW});
        clk_d  = (state_nx == SCK_HIGH) ^ CPOL;
        busy_d = (state_nx != IDLE);
        done_d = (state_nx == GAP) && (state != GAP);
        mosi_d = pin_mosi;
        if (state == IDLE && state_nx == SETUP) begin
            mosi_d = value_mosi[WIDTH-1];
        end else if (state == SCK_HIGH && state_nx == SCK_LOW) begin
            mosi_d = shreg[WIDTH-2];
        end
    end

    always_ff @(posedge system_clk or negedge system_nrst) begin
        if (!system_nrst) begin
            pin_ncs    <= 1'b1;
            pin_clk    <= CPOL;
            pin_mosi   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            value_miso <= '0;
            shreg      <= '0;
            tmr        <= '0;
            bits       <= '0;
        end else begin
            pin_ncs  <= ncs_d;
            pin_clk  <= clk_d;
            pin_mosi <= mosi_d;
            busy     <= busy_d;
            done     <= done_d;
            if (state_nx != state) begin
                tmr <= T_LOAD;
            end else if (!last) begin
                tmr <= tmr - 1'b1;
            end
            if (state == IDLE && start) begin
                shreg <= value_mosi;
                bits  <= '0;
            end else if (state == SCK_HIGH && last) begin
                shreg <= {shreg[WIDTH-2:0], pin_miso};
                bits  <= bits + 1'b1;
            end
            if (done_d) begin
                value_miso <= shreg;
            end
        end
    end

endmodule

// File: tb/tb_simple_spi_master.sv
// tb_simple_spi_master: three configurations of the SPI master against a bench-side
// slave model, a pin monitor and loopback; expectations come from transfer arithmetic.
module tb_simple_spi_master;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc_no = 0;
    int   n_checks = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_no <= cyc_no + 1;

    // A: WIDTH 8, HALF_PERIOD 2, CPOL 0
    logic       start_a = 1'b0;
    logic [7:0] mosi_a = '0;
    logic [7:0] vmiso_a;
    logic       busy_a, done_a, ncs_a, sck_a, so_a, si_a;

    simple_spi_master #(.WIDTH(8), .CPOL(1'b0), .HALF_PERIOD(2)) u_a (
        .system_clk(clk), .system_nrst(rst_n), .start(start_a),
        .value_mosi(mosi_a), .value_miso(vmiso_a), .busy(busy_a),
        .done(done_a), .pin_ncs(ncs_a), .pin_clk(sck_a),
        .pin_mosi(so_a), .pin_miso(si_a)
    );

    // B: WIDTH 8, HALF_PERIOD 1, CPOL 1
    logic       start_b = 1'b0;
    logic [7:0] mosi_b = '0;
    logic [7:0] vmiso_b;
    logic       busy_b, done_b, ncs_b, sck_b, so_b, si_b;

    simple_spi_master #(.WIDTH(8), .CPOL(1'b1), .HALF_PERIOD(1)) u_b (
        .system_clk(clk), .system_nrst(rst_n), .start(start_b),
        .value_mosi(mosi_b), .value_miso(vmiso_b), .busy(busy_b),
        .done(done_b), .pin_ncs(ncs_b), .pin_clk(sck_b),
        .pin_mosi(so_b), .pin_miso(si_b)
    );

    // C: default parameters, MOSI looped back to MISO
    logic        start_c = 1'b0;
    logic [31:0] mosi_c = '0;
    logic [31:0] vmiso_c;
    logic        busy_c, done_c, ncs_c, sck_c, so_c;

    simple_spi_master u_c (
        .system_clk(clk), .system_nrst(rst_n), .start(start_c),
        .value_mosi(mosi_c), .value_miso(vmiso_c), .busy(busy_c),
        .done(done_c), .pin_ncs(ncs_c), .pin_clk(sck_c),
        .pin_mosi(so_c), .pin_miso(so_c)
    );

    // Slave + monitor for A: slave shifts on SCK fall, master bits captured on SCK rise.
    logic [7:0] a_word = '0;
    logic [7:0] a_sh = '0;
    logic [7:0] a_cap = '0;
    logic       a_pclk = 1'b0;
    int         a_nbits = 0, a_low = 0, a_low_last = 0, a_dones = 0;

    assign si_a = a_sh[7];

    always @(negedge clk) begin
        if (ncs_a) begin
            a_sh <= a_word;
            if (a_low > 0) a_low_last <= a_low;
            a_low <= 0;
        end else begin
            a_low <= a_low + 1;
            if (!a_pclk && sck_a) begin
                a_cap   <= {a_cap[6:0], so_a};
                a_nbits <= a_nbits + 1;
            end
            if (a_pclk && !sck_a) a_sh <= a_sh << 1;
        end
        if (done_a) a_dones <= a_dones + 1;
        a_pclk <= sck_a;
    end

    // Slave + monitor for B: CPOL 1, so the leading (sampling) edge is a pin fall.
    logic [7:0] b_word = '0;
    logic [7:0] b_sh = '0;
    logic [7:0] b_cap = '0;
    logic       b_pclk = 1'b1;
    int         b_nbits = 0, b_low = 0, b_low_last = 0;
    int         b_high = 0, b_high_last = 0, b_dones = 0;

    assign si_b = b_sh[7];

    always @(negedge clk) begin
        if (ncs_b) begin
            b_sh <= b_word;
            if (b_low > 0) b_low_last <= b_low;
            b_low  <= 0;
            b_high <= b_high + 1;
        end else begin
            if (b_high > 0) b_high_last <= b_high;
            b_high <= 0;
            b_low  <= b_low + 1;
            if (b_pclk && !sck_b) begin
                b_cap   <= {b_cap[6:0], so_b};
                b_nbits <= b_nbits + 1;
            end
            if (!b_pclk && sck_b) b_sh <= b_sh << 1;
        end
        if (done_b) b_dones <= b_dones + 1;
        b_pclk <= sck_b;
    end

    typedef struct {
        logic [7:0] tx;
        logic [7:0] slave;
        logic [7:0] exp_rx;
        logic [7:0] exp_tx;
        int         exp_cyc;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One transfer on A; poke_at >= 0 pulses start at that cycle of the transfer.
    task automatic run_a(input vec_t v, input int poke_at, input string tag);
        int cyc, d0, n0;
        a_word = v.slave;
        @(negedge clk);
        d0 = a_dones;
        n0 = a_nbits;
        mosi_a = v.tx;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        mosi_a = 8'($urandom);
        check($sformatf("%s busy_rise", tag), busy_a, 1);
        cyc = 0;
        while (!done_a && cyc < 200) begin
            start_a = (cyc == poke_at);
            if (start_a) begin
                mosi_a = ~v.tx;
                check($sformatf("%s poke_in_low", tag), {ncs_a, sck_a}, 0);
                check($sformatf("%s poke_bits", tag), a_nbits - n0, 4);
            end
            @(negedge clk);
            cyc++;
        end
        start_a = 1'b0;
        check($sformatf("%s done_latency", tag), cyc, v.exp_cyc);
        check($sformatf("%s value_miso", tag), vmiso_a, v.exp_rx);
        @(negedge clk);
        check($sformatf("%s done_width", tag), done_a, 0);
        check($sformatf("%s busy_gap", tag), busy_a, 1);
        @(negedge clk);
        check($sformatf("%s busy_fall", tag), busy_a, 0);
        repeat (4) @(negedge clk);
        check($sformatf("%s ncs_idle", tag), ncs_a, 1);
        check($sformatf("%s mosi_bits", tag), a_cap, v.exp_tx);
        check($sformatf("%s sck_rises", tag), a_nbits - n0, 8);
        check($sformatf("%s ncs_low_len", tag), a_low_last, v.exp_cyc);
        check($sformatf("%s done_count", tag), a_dones - d0, 1);
        check($sformatf("%s rx_hold", tag), vmiso_a, v.exp_rx);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, n0, cyc;
        int stamps[3];
        logic [31:0] w;

        vecs[0] = '{8'hA5, 8'h3C, 8'h3C, 8'hA5, 34};
        for (int i = 1; i < 6; i++) begin
            vecs[i].tx      = 8'($urandom);
            vecs[i].slave   = 8'($urandom);
            vecs[i].exp_rx  = vecs[i].slave;
            vecs[i].exp_tx  = vecs[i].tx;
            vecs[i].exp_cyc = 2 * (1 + 2 * 8);
        end

        #2 rst_n = 1'b0;
        #1;
        check("rst ncs_a", ncs_a, 1);
        check("rst sck_a", sck_a, 0);
        check("rst sck_b", sck_b, 1);
        check("rst outs_a", {so_a, busy_a, done_a}, 0);
        check("rst vmiso_a", vmiso_a, 0);
        check("rst vmiso_c", vmiso_c, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) run_a(vecs[i], -1, $sformatf("vec%0d", i));

        // start during bit 3 low phase is ignored
        run_a(vecs[1], 16, "poke");

        // reset during bit 5 high phase aborts with no done
        a_word = 8'h5A;
        @(negedge clk);
        d0 = a_dones;
        mosi_a = 8'hC3;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (22) @(negedge clk);
        check("abort pre_sck", {ncs_a, sck_a}, 2'b01);
        rst_n = 1'b0;
        #1;
        check("abort ncs", ncs_a, 1);
        check("abort sck", sck_a, 0);
        check("abort outs", {so_a, busy_a, done_a}, 0);
        check("abort vmiso", vmiso_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("abort no_done", a_dones - d0, 0);
        run_a(vecs[0], -1, "post_rst");

        // B: start held high, back-to-back transfers
        b_word = 8'($urandom);
        mosi_b = 8'($urandom);
        @(negedge clk);
        check("b sck_idle", sck_b, 1);
        d0 = b_dones;
        n0 = b_nbits;
        start_b = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc = 0;
            while (!done_b && cyc < 100) begin
                @(negedge clk);
                cyc++;
            end
            stamps[k] = cyc_no;
            if (k == 2) start_b = 1'b0;
            check($sformatf("b%0d value_miso", k), vmiso_b, b_word);
            check($sformatf("b%0d mosi_bits", k), b_cap, mosi_b);
            if (k > 0) begin
                check($sformatf("b%0d period", k), stamps[k] - stamps[k-1], 19);
            end
            @(negedge clk);
        end
        repeat (25) @(negedge clk);
        check("b done_count", b_dones - d0, 3);
        check("b sck_pulses", b_nbits - n0, 24);
        check("b ncs_low_len", b_low_last, 17);
        check("b ncs_high_len", b_high_last, 2);
        check("b idle_pins", {ncs_b, sck_b}, 2'b11);

        // C: loopback, 32-bit default timing
        for (int k = 0; k < 3; k++) begin
            w = (k == 0) ? 32'hDEADBEEF : $urandom;
            @(negedge clk);
            mosi_c = w;
            start_c = 1'b1;
            @(negedge clk);
            start_c = 1'b0;
            mosi_c = $urandom;
            cyc = 0;
            while (!done_c && cyc < 400) begin
                @(negedge clk);
                cyc++;
            end
            check($sformatf("c%0d done_latency", k), cyc, 4 * (1 + 2 * 32));
            check($sformatf("c%0d loopback", k), vmiso_c, w);
            repeat (6) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/simple_spi_master.md
SIMPLE_SPI_MASTER -- requirements
Module: simple_spi_master

Interface
REQ-001 Parameter: WIDTH, default 32, bits per transfer; SHALL be >= 2.
REQ-002 Parameter: CPOL, default 1'b0, SCK idle level; pin_clk SHALL be the internal mode-0 clock XOR CPOL.
REQ-003 Parameter: HALF_PERIOD, default 4, system_clk cycles per SCK half period; SHALL be >= 1.
REQ-004 system_clk  input  1  sole clock; all state on rising edge.
REQ-005 system_nrst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  transfer request, sampled in IDLE only.
REQ-007 value_mosi  input  WIDTH  word to transmit, captured on accepted start.
REQ-008 value_miso  output  WIDTH  word received from slave, MSB first.
REQ-009 busy  output  1  high from the cycle after start acceptance until return to IDLE.
REQ-010 done  output  1  one-cycle pulse when value_miso becomes valid.
REQ-011 pin_ncs  output  1  active-low chip select.
REQ-012 pin_clk  output  1  SCK.
REQ-013 pin_mosi  output  1  serial data out.
REQ-014 pin_miso  input  1  serial data in.

Function
REQ-015 FSM states SHALL be: IDLE, SETUP, SCK_HIGH, SCK_LOW, GAP; each non-IDLE state lasts exactly HALF_PERIOD cycles, timed by a down-counter of width $clog2(HALF_PERIOD+1).
REQ-016 In IDLE with start=1, the block SHALL capture value_mosi into a WIDTH-bit shift register, clear the bit counter, and enter SETUP at cycle t0+1.
REQ-017 In SETUP: pin_ncs=0, internal clk=0, pin_mosi=captured MSB, valid from t0+1.
REQ-018 SETUP->SCK_HIGH: internal clk=1 (rising edge, Mode 0).
REQ-019 On the last cycle of SCK_HIGH, the block SHALL shift pin_miso into the register LSB and increment the bit counter (width $clog2(WIDTH+1)).
REQ-020 SCK_HIGH->SCK_LOW: internal clk=0; pin_mosi SHALL update to the next register MSB at this falling edge.
REQ-021 At the end of SCK_LOW, if the bit counter < WIDTH, the FSM SHALL go to SCK_HIGH; otherwise it SHALL go to GAP. The final SCK_LOW serves as CS hold time.
REQ-022 On entry to GAP: pin_ncs=1, done=1 for exactly that cycle, and value_miso SHALL be updated from the shift register and then held until the next done.
REQ-023 pin_ncs SHALL be low for exactly HALF_PERIOD*(1+2*WIDTH) consecutive cycles per transfer.
REQ-024 At the end of GAP, the FSM SHALL enter IDLE with busy=0; start is accepted in that same IDLE cycle (back-to-back minimum ncs-high time is HALF_PERIOD+1 cycles).
REQ-025 While busy=1, start and value_mosi SHALL be ignored.
REQ-026 pin_mosi SHALL hold its last value while pin_ncs=1; pin_clk SHALL equal CPOL whenever the FSM is not in SCK_HIGH.
REQ-027 No combinational path SHALL exist from pin_miso to any output; all pin outputs SHALL be registered.

Reset
REQ-028 While system_nrst=0, the block SHALL force immediately, independent of the clock: state=IDLE, pin_ncs=1, pin_clk=CPOL, pin_mosi=0, busy=0, done=0, value_miso=0, shift register=0, counters=0.
REQ-029 Reset asserted mid-transfer SHALL abort the transfer without a done pulse; the first start after reset release SHALL begin a clean transfer.

Verification
REQ-030 WIDTH=8, HALF_PERIOD=2, CPOL=0, value_mosi=8'hA5, bench drives MISO bits of 8'h3C changing on SCK falling edges -> MOSI bits 1,0,1,0,0,1,0,1 on rising edges; value_miso=8'h3C at done; ncs low 34 cycles.
REQ-031 Same setup, CPOL=1 -> pin_clk idles high and shows 8 low-going pulses; data identical to REQ-030.
REQ-032 HALF_PERIOD=1, start held high continuously with WIDTH=8 -> transfers repeat with ncs low 17 cycles and high 2 cycles; exactly one done per transfer.
REQ-033 start pulsed during SCK_LOW of bit 3 -> ignored; no extra transfer; busy timing unchanged.
REQ-034 system_nrst pulsed low during bit 5 -> pin_ncs=1 and pin_clk=CPOL asynchronously, no done pulse; the next start yields a correct full transfer.
REQ-035 WIDTH=32, default parameters, loopback of pin_mosi to pin_miso, value_mosi=32'hDEADBEEF -> value_miso=32'hDEADBEEF; done exactly 4*(1+64)=260 cycles after t0+1.
